// File: rtl/chien_parallel_if.sv
// chien_parallel_if: handshake and data bundle for the parallel Chien search.
// The master side (key-equation stage) drives start/sigma/ce.
// The slave side (the search block) returns the beat stream and status.
interface chien_parallel_if #(
  parameter int unsigned M = 4,
  parameter int unsigned T = 3,
  parameter int unsigned P = 1,
  parameter int unsigned N = (1 << M) - 1
);
  localparam int unsigned CntW = $clog2(N + 1);

  logic                 start;
  logic [M*(T+1)-1:0]   sigma;
  logic                 ready;
  logic                 ce;
  logic                 valid;
  logic [P-1:0]         err;
  logic                 first;
  logic                 last;
  logic                 done;
  logic [CntW-1:0]      err_count;
  logic                 fail;

  modport master (
    output start, sigma, ce,
    input  ready, valid, err, first, last, done, err_count, fail
  );

  modport slave (
    input  start, sigma, ce,
    output ready, valid, err, first, last, done, err_count, fail
  );
endinterface

// File: rtl/chien_parallel.sv
// chien_parallel: Chien search over GF(2^M) that tests P consecutive field points per cycle.
// Beat c tests positions c*P .. c*P+P-1; err[k] flags sigma(alpha^(c*P+k)) == 0.
// Optional: define CHIEN_ERR_COUNT_EN for root counting and the err_count/fail check
// against deg(sigma); without it err_count and fail are tied to zero.
module chien_parallel #(
  parameter int unsigned M    = 4,
  parameter int unsigned T    = 3,
  parameter int unsigned P    = 1,
  parameter int unsigned N    = (1 << M) - 1,
  parameter int unsigned Poly = 32'h13  // field polynomial including the x^M term
) (
  input logic             clk,
  input logic             reset,
  chien_parallel_if.slave bus
);

  localparam int unsigned Order = (1 << M) - 1;
  localparam int unsigned Beats = (N + P - 1) / P;
  localparam int unsigned CntW  = $clog2(N + 1);
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [M-1:0] PolyLow = M'(Poly);

  // Standard-basis GF(2^M) multiply; used only with one constant operand.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned j = 0; j < M; j++) begin
      if (b[j]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PolyLow : '0);
    end
    return acc;
  endfunction

  // alpha^e with alpha = x, evaluated at elaboration time.
  function automatic logic [M-1:0] alpha_pow(input int unsigned e);
    logic [M-1:0] r;
    r = M'(1);
    for (int unsigned j = 0; j < e % Order; j++) r = gf_mul(r, M'(2));
    return r;
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic                ready;
  logic                load;
  logic                advance;
  logic                beat_last;

  logic [T:0][M-1:0]   sigma_in;
  logic [T:0][M-1:0]   coef_q;
  logic [T:0][M-1:0]   coef_step;
  logic [BeatW-1:0]    beat_q;

  logic [M-1:0]        term [P][T+1];
  logic [M-1:0]        syn  [P];
  logic [P-1:0]        err_raw;
  logic [P-1:0]        err_masked;

  logic                valid_q;
  logic [P-1:0]        err_q;
  logic                first_q;
  logic                last_q;
  logic                done_q;

  assign sigma_in  = bus.sigma;
  assign beat_last = (beat_q == BeatW'(Beats - 1));

  // Constant multipliers: per-beat coefficient step and per-lane twiddles.
  for (genvar i = 0; i <= T; i++) begin : g_step
    localparam logic [M-1:0] Step = alpha_pow(i * P);
    assign coef_step[i] = gf_mul(coef_q[i], Step);
  end

  for (genvar k = 0; k < P; k++) begin : g_lane
    for (genvar i = 0; i <= T; i++) begin : g_term
      localparam logic [M-1:0] Twiddle = alpha_pow(i * k);
      assign term[k][i] = gf_mul(coef_q[i], Twiddle);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (bus.ce && beat_last) state_d = StDone;
      StDone:  state_d = bus.start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: handshake and datapath strobes
  always_comb begin
    ready   = (state_q != StRun);
    load    = ready && bus.start;
    advance = (state_q == StRun) && bus.ce;
  end

  assign bus.ready = ready;

  // Coefficient registers and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_q <= '0;
      beat_q <= '0;
    end else if (load) begin
      coef_q <= sigma_in;
      beat_q <= '0;
    end else if (advance) begin
      coef_q <= coef_step;
      beat_q <= beat_q + BeatW'(1);
    end
  end

  // Per-lane evaluation: zero syndrome means a root at that position
  always_comb begin
    for (int unsigned k = 0; k < P; k++) begin
      syn[k] = '0;
      for (int unsigned i = 0; i <= T; i++) syn[k] = syn[k] ^ term[k][i];
      err_raw[k] = (syn[k] == '0);
    end
  end

  // Lanes past position N-1 (only possible on the last beat) never flag
  always_comb begin
    for (int unsigned k = 0; k < P; k++) begin
      err_masked[k] = err_raw[k] && ((32'(beat_q) * P + k) < N);
    end
  end

  // Registered beat outputs; done trails the last beat by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= advance;
      done_q  <= (state_q == StDone);
      if (advance) begin
        err_q   <= err_masked;
        first_q <= (beat_q == '0);
        last_q  <= beat_last;
      end else begin
        err_q   <= '0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.first = first_q;
  assign bus.last  = last_q;
  assign bus.done  = done_q;

`ifdef CHIEN_ERR_COUNT_EN
  localparam int unsigned DegW = (T > 0) ? $clog2(T + 1) : 1;

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] beat_pop;
  logic [DegW-1:0] deg_q;
  logic [DegW-1:0] deg_in;
  logic            fail_q;

  // Roots found in the current beat
  always_comb begin
    beat_pop = '0;
    for (int unsigned k = 0; k < P; k++) beat_pop = beat_pop + CntW'(err_masked[k]);
  end

  // Degree of the incoming polynomial: highest nonzero coefficient index
  always_comb begin
    deg_in = '0;
    for (int unsigned i = 0; i <= T; i++) begin
      if (sigma_in[i] != '0) deg_in = DegW'(i);
    end
  end

  // Root counter, latched degree, and fail flag presented alongside done
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      deg_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      if (load) begin
        cnt_q <= '0;
        deg_q <= deg_in;
      end else if (advance) begin
        cnt_q <= cnt_q + beat_pop;
      end
      // The DONE-cycle compare wins over a back-to-back start so done carries its own fail.
      if (state_q == StDone) fail_q <= (32'(cnt_q) != 32'(deg_q));
      else if (load)         fail_q <= 1'b0;
    end
  end

  assign bus.err_count = cnt_q;
  assign bus.fail      = fail_q;
`else
  assign bus.err_count = '0;
  assign bus.fail      = 1'b0;
`endif

endmodule

// File: tb/tb_chien_parallel.sv
// tb_chien_parallel: two instances (P=1 and P=4, M=4, x^4+x+1, T=3) checked against a
// log/antilog GF(16) model that evaluates sigma at every position with Horner's rule.
module tb_chien_parallel;

  logic        clk;
  logic        reset;
  logic        start_r;
  logic        ce_r;
  logic [15:0] sigma_r;
  bit          sel;

  int checks;
  int errors;

  int exp_t [15];
  int log_t [16];

  chien_parallel_if #(.M(4), .T(3), .P(1)) bus1 ();
  chien_parallel_if #(.M(4), .T(3), .P(4)) bus4 ();

  chien_parallel #(.M(4), .T(3), .P(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  chien_parallel #(.M(4), .T(3), .P(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  assign bus1.start = start_r & ~sel;
  assign bus4.start = start_r & sel;
  assign bus1.sigma = sigma_r;
  assign bus4.sigma = sigma_r;
  assign bus1.ce    = ce_r;
  assign bus4.ce    = ce_r;

  logic       o_ready, o_valid, o_first, o_last, o_done, o_fail;
  logic [3:0] o_err;
  logic [3:0] o_cnt;

  always_comb begin
    if (sel) begin
      o_ready = bus4.ready; o_valid = bus4.valid; o_first = bus4.first;
      o_last  = bus4.last;  o_done  = bus4.done;  o_fail  = bus4.fail;
      o_err   = bus4.err;   o_cnt   = bus4.err_count;
    end else begin
      o_ready = bus1.ready; o_valid = bus1.valid; o_first = bus1.first;
      o_last  = bus1.last;  o_done  = bus1.done;  o_fail  = bus1.fail;
      o_err   = {3'b000, bus1.err}; o_cnt = bus1.err_count;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 15];
  endfunction

  function automatic bit is_root(input logic [15:0] sig, input int pos);
    int x;
    int acc;
    x   = exp_t[pos % 15];
    acc = 0;
    for (int i = 3; i >= 0; i--) acc = gmul(acc, x) ^ int'(sig[i*4 +: 4]);
    return acc == 0;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "/ready"}, o_ready, 1);
    chk({tag, "/valid"}, o_valid, 0);
    chk({tag, "/done"},  o_done,  0);
    chk({tag, "/err"},   o_err,   0);
    chk({tag, "/first"}, o_first, 0);
    chk({tag, "/last"},  o_last,  0);
    chk({tag, "/cnt"},   o_cnt,   0);
    chk({tag, "/fail"},  o_fail,  0);
  endtask

  // One search on instance s; optional 3-cycle ce stall after beat stall_beat,
  // optional reset right after beat reset_beat is observed.
  task automatic run_search(input bit s, input logic [15:0] sig, input int stall_beat,
                            input int reset_beat, input string tag);
    int         p, beats, nb, stall_left, last_cyc, exp_cnt, deg;
    bit         done_seen, exp_fail;
    logic [3:0] want;
    p     = s ? 4 : 1;
    beats = (15 + p - 1) / p;
    deg   = 0;
    for (int i = 0; i < 4; i++) if (sig[i*4 +: 4] != 4'd0) deg = i;
    sel = s;
    #1;
    for (int w = 0; w < 50 && !o_ready; w++) @(negedge clk);
    chk({tag, "/ready_before"}, o_ready, 1);
    sigma_r = sig;
    start_r = 1'b1;
    ce_r    = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    chk({tag, "/ready_run"}, o_ready, 0);
    nb = 0; stall_left = 0; last_cyc = -100; exp_cnt = 0; done_seen = 0;
    for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        chk({tag, "/stall_valid"}, o_valid, 0);
        stall_left--;
        if (stall_left == 0) ce_r = 1'b1;
      end else if (o_valid) begin
        want = '0;
        for (int k = 0; k < p; k++) begin
          if (nb * p + k < 15 && is_root(sig, nb * p + k)) begin
            want[k] = 1'b1;
            exp_cnt++;
          end
        end
        chk($sformatf("%s/err[%0d]", tag, nb), o_err, want);
        chk($sformatf("%s/first[%0d]", tag, nb), o_first, nb == 0);
        chk($sformatf("%s/last[%0d]", tag, nb), o_last, nb == beats - 1);
`ifdef CHIEN_ERR_COUNT_EN
        chk($sformatf("%s/cnt[%0d]", tag, nb), o_cnt, exp_cnt);
`else
        chk($sformatf("%s/cnt[%0d]", tag, nb), o_cnt, 0);
`endif
        if (nb == beats - 1) last_cyc = cyc;
        if (nb == reset_beat) begin
          reset = 1'b1;
          @(negedge clk);
          chk_idle_outputs({tag, "/after_reset"});
          reset = 1'b0;
          for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk({tag, "/no_done"}, o_done, 0);
            chk({tag, "/no_valid"}, o_valid, 0);
          end
          return;
        end
        if (nb == stall_beat) begin
          ce_r       = 1'b0;
          stall_left = 3;
        end
        nb++;
      end else if (!o_done) begin
        chk({tag, "/unexpected_gap"}, o_valid, 1);
      end
      if (o_done) begin
        done_seen = 1;
`ifdef CHIEN_ERR_COUNT_EN
        exp_fail = (exp_cnt != deg);
        chk({tag, "/done_cnt"}, o_cnt, exp_cnt);
`else
        exp_fail = 0;
        chk({tag, "/done_cnt"}, o_cnt, 0);
`endif
        chk({tag, "/done_latency"}, cyc - last_cyc, 1);
        chk({tag, "/beats"}, nb, beats);
        chk({tag, "/done_fail"}, o_fail, exp_fail);
        chk({tag, "/done_ready"}, o_ready, 1);
        chk({tag, "/done_valid"}, o_valid, 0);
      end
    end
    chk({tag, "/done_seen"}, done_seen, 1);
    @(negedge clk);
    chk({tag, "/done_pulse"}, o_done, 0);
  endtask

  initial begin
    int v;
    checks  = 0;
    errors  = 0;
    v = 1;
    for (int j = 0; j < 15; j++) begin
      exp_t[j] = v;
      log_t[v] = j;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 'h13;
    end
    log_t[0] = 0;

    reset   = 1'b1;
    start_r = 1'b0;
    ce_r    = 1'b1;
    sigma_r = '0;
    sel     = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset_p1");
    sel = 1'b1;
    #1;
    chk_idle_outputs("reset_p4");
    reset = 1'b0;
    @(negedge clk);

    run_search(1'b0, 16'h0001, -1, -1, "c1_const");
    run_search(1'b0, 16'h0011, -1, -1, "c2_1px");
    run_search(1'b1, 16'h0231, -1, -1, "c3_two_roots");
    run_search(1'b1, 16'h0118, -1, -1, "c4_irreducible");
    run_search(1'b0, 16'h0011, 5, -1, "c5_stall");
    run_search(1'b0, 16'h0011, -1, 7, "c6_reset");
    run_search(1'b0, 16'h0001, -1, -1, "c6_rerun");
    run_search(1'b1, 16'h0000, -1, -1, "zero_sigma");

    for (int r = 0; r < 3; r++) begin
      run_search(1'b0, 16'($urandom()), -1, -1, $sformatf("rnd_p1_%0d", r));
      run_search(1'b1, 16'($urandom()), int'($urandom_range(0, 2)), -1,
                 $sformatf("rnd_p4_%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
